// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults and the dual-write byte merge rule
package regfile_mp_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] d0,
                                            input logic [7:0] d1, input logic be0, input logic be1);
    return be1 ? d1 : be0 ? d0 : old_b;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, set by reservations and cleared by writes
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = NRD_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic                  busy_set_en,
  input  logic [ADDR_W-1:0]     busy_set_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy,
  output logic [2**ADDR_W-1:0]  busy_vec
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] set_v, clr_v;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    set_v[busy_set_addr] = busy_set_en;
    clr_v[wr0_addr] = wr0_en;
    clr_v[wr1_addr] = clr_v[wr1_addr] | wr1_en;
    if (ZERO_REG) set_v[0] = 1'b0;
  end
  // a new reservation beats a same-cycle clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_vec <= '0;
    else busy_vec <= set_v | (busy_vec & ~clr_v);
  always_comb
    for (int i = 0; i < NRD; i++)
      rd_busy[i] = busy_vec[rd_addr[i*ADDR_W +: ADDR_W]] &&
                   !(BYPASS && clr_v[rd_addr[i*ADDR_W +: ADDR_W]] && !set_v[rd_addr[i*ADDR_W +: ADDR_W]]);
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with byte enables, forwarding and busy scoreboard
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = NRD_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr0_en,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic [DATA_W/8-1:0]   wr0_be,
  input  logic [DATA_W/8-1:0]   wr1_be,
  input  logic                  busy_set_en,
  input  logic [ADDR_W-1:0]     busy_set_addr,
  output logic [2**ADDR_W-1:0]  busy_vec
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] nxt [DEPTH];
  logic [DEPTH-1:0]  hit0, hit1;
  // hits are gated by reset and the zero register so nxt doubles as the forwarded value
  always_comb
    for (int n = 0; n < DEPTH; n++) begin
      hit0[n] = rst && wr0_en && wr0_addr == ADDR_W'(n) && !(ZERO_REG && n == 0);
      hit1[n] = rst && wr1_en && wr1_addr == ADDR_W'(n) && !(ZERO_REG && n == 0);
      for (int b = 0; b < NB; b++)
        nxt[n][b*8 +: 8] = merge_byte(mem[n][b*8 +: 8], wr0_data[b*8 +: 8], wr1_data[b*8 +: 8],
                                      hit0[n] && wr0_be[b], hit1[n] && wr1_be[b]);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
    else for (int n = 0; n < DEPTH; n++) mem[n] <= nxt[n];
  always_comb
    for (int i = 0; i < NRD; i++)
      rd_data[i*DATA_W +: DATA_W] = BYPASS ? nxt[rd_addr[i*ADDR_W +: ADDR_W]] : mem[rd_addr[i*ADDR_W +: ADDR_W]];
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NRD(NRD), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .rd_addr(rd_addr), .rd_busy(rd_busy), .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against an array model
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NRD = 2, DEPTH = 32;
  logic clk = 1'b0, rst = 1'b0;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0] rd_busy, rd_busy_nb;
  logic wr0_en, wr1_en, busy_set_en;
  logic [AW-1:0] wr0_addr, wr1_addr, busy_set_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [3:0] wr0_be, wr1_be;
  logic [DEPTH-1:0] busy_vec, busy_vec_nb;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] m_reg [DEPTH];
  logic m_busy [DEPTH];
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr1_en(wr1_en), .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data), .wr0_be(wr0_be), .wr1_be(wr1_be),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .busy_vec(busy_vec)
  );
  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr1_en(wr1_en), .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data), .wr0_be(wr0_be), .wr1_be(wr1_be),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .busy_vec(busy_vec_nb)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    wr0_en = 0; wr1_en = 0; busy_set_en = 0;
    wr0_addr = 0; wr1_addr = 0; busy_set_addr = 0;
    wr0_data = 0; wr1_data = 0; wr0_be = 0; wr1_be = 0;
  endtask
  task automatic m_clear();
    for (int a = 0; a < DEPTH; a++) begin
      m_reg[a] = '0;
      m_busy[a] = 1'b0;
    end
  endtask
  function automatic logic [DW-1:0] m_next(input int a);
    logic [DW-1:0] v;
    v = m_reg[a];
    if (!rst || a == 0) return v;
    for (int b = 0; b < 4; b++)
      if (wr1_en && int'(wr1_addr) == a && wr1_be[b]) v[b*8 +: 8] = wr1_data[b*8 +: 8];
      else if (wr0_en && int'(wr0_addr) == a && wr0_be[b]) v[b*8 +: 8] = wr0_data[b*8 +: 8];
    return v;
  endfunction
  function automatic logic m_set(input int a);
    return busy_set_en && int'(busy_set_addr) == a && a != 0;
  endfunction
  function automatic logic m_clr(input int a);
    return (wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a);
  endfunction
  task automatic step(input string tag);
    logic [DW-1:0] nr [DEPTH];
    logic nbz [DEPTH];
    logic [DEPTH-1:0] bv;
    int a;
    #1;
    for (int k = 0; k < DEPTH; k++) bv[k] = m_busy[k];
    chk({tag, ".busy_vec"}, 64'(busy_vec), 64'(bv));
    chk({tag, ".busy_vec_nb"}, 64'(busy_vec_nb), 64'(bv));
    for (int i = 0; i < NRD; i++) begin
      a = int'(rd_addr[i*AW +: AW]);
      chk({tag, ".rd_data"}, 64'(rd_data[i*DW +: DW]), 64'(m_next(a)));
      chk({tag, ".rd_data_nb"}, 64'(rd_data_nb[i*DW +: DW]), 64'(m_reg[a]));
      chk({tag, ".rd_busy"}, 64'(rd_busy[i]), 64'(m_busy[a] && !(m_clr(a) && !m_set(a))));
      chk({tag, ".rd_busy_nb"}, 64'(rd_busy_nb[i]), 64'(m_busy[a]));
    end
    for (int k = 0; k < DEPTH; k++) begin
      nr[k] = m_next(k);
      nbz[k] = rst && (m_set(k) || (m_busy[k] && !m_clr(k)));
    end
    @(posedge clk);
    m_reg = nr;
    m_busy = nbz;
    @(negedge clk);
  endtask
  initial begin
    idle();
    rd_addr = '0;
    m_clear();
    #1;
    chk("reset.busy_vec", 64'(busy_vec), 64'h0);
    chk("reset.rd_data", 64'(rd_data), 64'h0);
    @(negedge clk);
    rst = 1;
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hDEADBEEF; wr0_be = 4'hF;
    busy_set_en = 1; busy_set_addr = 6; rd_addr = {5'd3, 5'd3};
    step("first_write");
    idle();
    #1;
    chk("r3_written", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("r6_busy", 64'(busy_vec[6]), 64'h1);
    rst = 0;
    #1;
    chk("async_rst.r3", 64'(rd_data[31:0]), 64'h0);
    chk("async_rst.busy_vec", 64'(busy_vec), 64'h0);
    m_clear();
    @(negedge clk);
    rst = 1;
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11223344; wr0_be = 4'hF; rd_addr = {5'd0, 5'd5};
    step("r5_init");
    wr0_data = 32'hAABBCCDD; wr0_be = 4'b0101;
    step("r5_bytes");
    idle();
    #1;
    chk("byte_write", 64'(rd_data[31:0]), 64'h11BB33DD);
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h0; wr0_be = 4'hF;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'hFFFFFFFF; wr1_be = 4'b0011; rd_addr = {5'd0, 5'd7};
    step("collide");
    idle();
    #1;
    chk("collision", 64'(rd_data[31:0]), 64'h0000FFFF);
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h12345678; wr0_be = 4'hF; rd_addr = {5'd0, 5'd9};
    #1;
    chk("bypass.on", 64'(rd_data[31:0]), 64'h12345678);
    chk("bypass.off", 64'(rd_data_nb[31:0]), 64'h0);
    step("bypass");
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; wr0_be = 4'hF;
    busy_set_en = 1; busy_set_addr = 0; rd_addr = {5'd0, 5'd0};
    step("zero_reg");
    idle();
    #1;
    chk("zero.rd", 64'(rd_data[31:0]), 64'h0);
    chk("zero.busy", 64'(busy_vec[0]), 64'h0);
    busy_set_en = 1; busy_set_addr = 4; rd_addr = {5'd0, 5'd4};
    step("sb_set");
    idle();
    #1;
    chk("sb.set", 64'(busy_vec[4]), 64'h1);
    busy_set_en = 1; busy_set_addr = 4; wr0_en = 1; wr0_addr = 4; wr0_be = 4'h0;
    step("sb_set_clr");
    idle();
    #1;
    chk("sb.set_wins", 64'(busy_vec[4]), 64'h1);
    wr1_en = 1; wr1_addr = 4; wr1_be = 4'h0; rd_addr = {5'd0, 5'd4};
    #1;
    chk("sb.rd_busy_bypass", 64'(rd_busy[0]), 64'h0);
    chk("sb.rd_busy_nb", 64'(rd_busy_nb[0]), 64'h1);
    step("sb_clr");
    idle();
    #1;
    chk("sb.cleared", 64'(busy_vec[4]), 64'h0);
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 39) != 0);
      if (!rst) m_clear();
      wr0_en = $urandom_range(0, 1); wr1_en = $urandom_range(0, 2) == 0;
      wr0_addr = AW'($urandom_range(0, 7)); wr1_addr = AW'($urandom_range(0, 7));
      wr0_data = $urandom; wr1_data = $urandom;
      wr0_be = 4'($urandom); wr1_be = 4'($urandom);
      busy_set_en = $urandom_range(0, 2) == 0; busy_set_addr = AW'($urandom_range(0, 7));
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      step("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
